// File: rtl/cbus_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder_pkg
//  Purpose  : Shared cbus transaction types used by the cbus RAM responder:
//             request/response structs, access size, burst length and AXI
//             burst type encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cbus_ram_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Burst length is encoded as number of beats minus one.
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_type_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        logic [31:0]     addr;
        logic [7:0]      strobe;
        logic [63:0]     data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/cbus_ram_responder_ram.sv
`default_nettype none
// ============================================================================
//  Module   : RAM_SinglePort
//  Purpose  : Single-port RAM with per-byte write strobes. Contents are never
//             cleared. READ_LATENCY 0 gives an asynchronous read, any other
//             value a one-cycle registered read.
//  Ports    : clk    - clock
//             en     - write enable for this cycle
//             addr   - word address (shared by read and write)
//             strobe - byte-lane write enables
//             wdata  - write data
//             rdata  - read data
//  Revision : 1.0 - initial release
// ============================================================================
module RAM_SinglePort #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int READ_LATENCY = 0
) (
    input  logic                             clk,
    input  logic                             en,
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] strobe,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]            rdata
);

    localparam int c_nbytes = DATA_WIDTH / BYTE_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (strobe[b]) begin
                    r_mem[addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_async_read
            assign rdata = r_mem[addr];
        end else begin : g_sync_read
            logic [DATA_WIDTH-1:0] r_rdata;
            always_ff @(posedge clk) begin
                r_rdata <= r_mem[addr];
            end
            assign rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cbus_ram_responder
//  Purpose  : cbus responder serving single-beat and burst reads/writes from
//             on-chip 64-bit word memory. Used as backing memory for the I/D
//             caches behind the cbus arbiter.
//  Ports    : clk   - clock
//             reset - synchronous, active-low
//             creq  - request from initiator (cbus_req_t)
//             cresp - response to initiator (ready, last, data)
//             busy  - transaction in progress
//  Config   : CBUS_RESP_BACKPRESSURE_EN - when defined, an 8-bit LFSR gates
//             ready during bursts to exercise initiator stall handling.
//  Revision : 1.0 - initial release
// ============================================================================
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy
);

    localparam int          c_aw        = $clog2(MEM_WORDS);
    // WAIT lasts LATENCY cycles: the counter is loaded with LATENCY-1 and
    // BURST is entered when it reads zero.
    localparam logic [3:0]  c_wait_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [c_aw-1:0] r_idx,      w_idx_nxt;
    mlen_t           r_beat,     w_beat_nxt;
    mlen_t           r_len,      w_len_nxt;
    logic            r_is_write, w_is_write_nxt;
    axi_burst_type_t r_burst,    w_burst_nxt;
    logic [3:0]      r_wait,     w_wait_nxt;

    logic            w_beat_ok;
    logic            w_ready;
    logic            w_last;
    logic            w_ram_en;
    logic [63:0]     w_rdata;

    // Size and the address bits outside the word index do not affect the
    // response; the initiator picks byte lanes itself.
    logic            w_unused;
    assign w_unused = ^{creq.size, creq.addr[31:c_aw+3], creq.addr[2:0]};

`ifdef CBUS_RESP_BACKPRESSURE_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_beat_ok = r_lfsr[0];
`else
    assign w_beat_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_beat     <= '0;
            r_len      <= '0;
            r_is_write <= 1'b0;
            r_burst    <= AXI_BURST_FIXED;
            r_wait     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_beat     <= w_beat_nxt;
            r_len      <= w_len_nxt;
            r_is_write <= w_is_write_nxt;
            r_burst    <= w_burst_nxt;
            r_wait     <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_beat_nxt     = r_beat;
        w_len_nxt      = r_len;
        w_is_write_nxt = r_is_write;
        w_burst_nxt    = r_burst;
        w_wait_nxt     = r_wait;

        // A beat is only acknowledged while the request is still valid and
        // reset is released, so an aborted or reset cycle never writes.
        w_ready = (r_state == BURST) && creq.valid && reset && w_beat_ok;
        w_last  = w_ready && (r_beat == r_len);

        case (r_state)
            IDLE: begin
                if (creq.valid) begin
                    w_is_write_nxt = creq.is_write;
                    w_len_nxt      = creq.len;
                    w_burst_nxt    = creq.burst;
                    w_idx_nxt      = creq.addr[c_aw+2:3];
                    w_beat_nxt     = '0;
                    if (LATENCY > 0) begin
                        w_state_nxt = WAIT;
                        w_wait_nxt  = c_wait_load;
                    end else begin
                        w_state_nxt = BURST;
                    end
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    w_state_nxt = IDLE;
                end else if (r_wait == 4'd0) begin
                    w_state_nxt = BURST;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    w_state_nxt = IDLE;
                end else if (w_ready) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                    w_beat_nxt = r_beat + 4'd1;
                    // WRAP is served as INCR; only FIXED holds the index.
                    if (r_burst != AXI_BURST_FIXED) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_ram_en = w_ready && r_is_write;

    RAM_SinglePort #(
        .ADDR_WIDTH   (c_aw),
        .DATA_WIDTH   (64),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (0)
    ) u_ram (
        .clk    (clk),
        .en     (w_ram_en),
        .addr   (r_idx),
        .strobe (creq.strobe),
        .wdata  (creq.data),
        .rdata  (w_rdata)
    );

    always_comb begin
        cresp       = '0;
        cresp.ready = w_ready;
        cresp.last  = w_last;
        cresp.data  = ((r_state == BURST) && !r_is_write) ? w_rdata : 64'd0;
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cbus_ram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cbus_ram_responder
//  Purpose  : Self-checking bench for cbus_ram_responder. A driver issues
//             directed and random bursts and pushes expected acks into a
//             queue computed from a word-array memory model; a monitor pops
//             and compares on every ready beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cbus_ram_responder;
    import cbus_ram_responder_pkg::*;

    localparam int MEM_WORDS = 4096;
    localparam int LATENCY   = 1;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;
    logic       busy;

    always #5 clk = ~clk;

    cbus_ram_responder #(
        .MEM_WORDS (MEM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp),
        .busy  (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flat word array plus a flag telling whether the word
    // holds fully defined contents.
    logic [63:0] model_mem [MEM_WORDS];
    bit          known     [MEM_WORDS];
    logic [63:0] wdat      [16];

    typedef struct packed {
        logic        is_write;
        logic        last;
        logic        chk;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every acknowledged beat must match the next expected beat.
    always @(negedge clk) begin
        if (cresp.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_last", {63'd0, cresp.last}, {63'd0, mon_e.last});
                if (!mon_e.is_write && mon_e.chk) begin
                    check("read_data", cresp.data, mon_e.data);
                end
            end
        end
    end

    task automatic idle();
        creq.valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues one burst starting at posedge+1 with the DUT idle (or going
    // idle this cycle). abort_after>0 pulses reset after that many acks.
    task automatic run_burst(input bit wr, input logic [31:0] addr, input int len,
                             input axi_burst_type_t bt, input logic [7:0] strb,
                             input int abort_after);
        int nb;
        int base;
        int t_issue;
        int acks;
        int first;
        int lastc;
        int guard;
        nb   = (abort_after > 0) ? abort_after : len + 1;
        base = int'(addr >> 3) % MEM_WORDS;
        for (int i = 0; i < nb; i++) begin
            int   w;
            exp_t e;
            w = (bt == AXI_BURST_FIXED) ? base : (base + i) % MEM_WORDS;
            e.is_write = wr;
            e.last     = (i == len);
            e.chk      = 1'b0;
            e.data     = 64'd0;
            if (wr) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model_mem[w][b*8 +: 8] = wdat[i][b*8 +: 8];
                end
                known[w] = known[w] || (strb == 8'hFF);
            end else begin
                e.chk  = known[w];
                e.data = model_mem[w];
            end
            exp_q.push_back(e);
        end

        t_issue       = cyc;
        creq.valid    = 1'b1;
        creq.is_write = wr;
        creq.size     = MSIZE8;
        creq.addr     = addr;
        creq.len      = mlen_t'(len);
        creq.burst    = bt;
        creq.strobe   = strb;
        creq.data     = wdat[0];
        acks  = 0;
        first = -1;
        lastc = -1;
        guard = 0;
        while (acks < nb && guard < 300) begin
            @(negedge clk);
            guard++;
            if (cresp.ready === 1'b1) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                acks++;
            end
            @(posedge clk); #1;
            if (acks < nb) creq.data = wdat[acks];
        end
        check("ack_count", 64'(acks), 64'(nb));
`ifndef CBUS_RESP_BACKPRESSURE_EN
        check("first_ready_latency", 64'(first - t_issue), 64'(1 + LATENCY));
        if (abort_after == 0) check("burst_span", 64'(lastc - first), 64'(len));
`endif
        if (abort_after > 0) begin
            reset = 1'b0;
            @(negedge clk);
            check("reset_cycle_ready", {63'd0, cresp.ready}, 64'd0);
            @(posedge clk); #1;
            reset      = 1'b1;
            creq.valid = 1'b0;
            @(negedge clk);
            check("after_reset_busy", {63'd0, busy}, 64'd0);
            check("after_reset_ready", {63'd0, cresp.ready}, 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        // Reset held with a valid request pending: no response may appear.
        reset      = 1'b0;
        creq       = '0;
        creq.valid = 1'b1;
        creq.len   = MLEN4;
        creq.burst = AXI_BURST_INCR;
        creq.addr  = 32'h8000_0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_ready", {63'd0, cresp.ready}, 64'd0);
            check("reset_last",  {63'd0, cresp.last},  64'd0);
            check("reset_busy",  {63'd0, busy},        64'd0);
        end
        @(posedge clk); #1;
        reset      = 1'b1;
        creq.valid = 1'b0;
        @(negedge clk);
        check("idle_after_release", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // 16-beat incrementing write then read back.
        for (int i = 0; i < 16; i++) wdat[i] = 64'h1111_1111_1111_1111 * i;
        run_burst(1'b1, 32'h8000_0080, 15, AXI_BURST_INCR, 8'hFF, 0);
        idle();
        run_burst(1'b0, 32'h8000_0080, 15, AXI_BURST_INCR, 8'hFF, 0);
        idle();

        // Partial-strobe single write over existing data.
        wdat[0] = 64'hDEAD_BEEF_CAFE_F00D;
        run_burst(1'b1, 32'h8000_0090, 0, AXI_BURST_FIXED, 8'h0F, 0);
        idle();
        run_burst(1'b0, 32'h8000_0090, 0, AXI_BURST_FIXED, 8'hFF, 0);
        idle();

        // Back-to-back: read accepted the cycle right after the write's last beat.
        for (int i = 0; i < 16; i++) wdat[i] = {$urandom(), $urandom()};
        run_burst(1'b1, 32'h8000_1000, 15, AXI_BURST_INCR, 8'hFF, 0);
        run_burst(1'b0, 32'h8000_1000, 15, AXI_BURST_INCR, 8'hFF, 0);
        idle();

        // Index wrap at the top of memory.
        for (int i = 0; i < 16; i++) wdat[i] = {$urandom(), $urandom()};
        run_burst(1'b1, 32'h8000_0000 + 32'((MEM_WORDS - 2) * 8), 3, AXI_BURST_INCR, 8'hFF, 0);
        idle();
        run_burst(1'b0, 32'h8000_0000 + 32'((MEM_WORDS - 2) * 8), 3, AXI_BURST_INCR, 8'hFF, 0);
        idle();

        // Reset after the 6th beat: only words 0-5 take the new data.
        for (int i = 0; i < 16; i++) wdat[i] = {$urandom(), $urandom()};
        run_burst(1'b1, 32'h8000_0000, 15, AXI_BURST_INCR, 8'hFF, 0);
        idle();
        for (int i = 0; i < 16; i++) wdat[i] = {$urandom(), $urandom()};
        run_burst(1'b1, 32'h8000_0000, 15, AXI_BURST_INCR, 8'hFF, 6);
        run_burst(1'b0, 32'h8000_0000, 15, AXI_BURST_INCR, 8'hFF, 0);
        idle();

        // Random traffic within the low 64 words; high address bits random.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) wdat[i] = {$urandom(), $urandom()};
            a = $urandom();
            a = (a & 32'hFFFF_8000) | (32'($urandom_range(0, 63)) << 3) | 32'($urandom_range(0, 7));
            run_burst(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 15)),
                      axi_burst_type_t'($urandom_range(0, 2)),
                      8'($urandom_range(0, 255)), 0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
